alu_share_ctrl: RTL and testbench

Two-requester arbiter and sequencer for the shared WIDTH-bit ALU built from the bit-slice ALU cells. It accepts operation requests over valid/ready handshakes and grants the ALU to one requester at a time. It registers the operands, drives the ALU for one execute cycle, and captures the result and flags. It then returns them on a single response channel tagged with the requester ID. It sits between the instruction-issue logic (requester 0) and the address/branch unit (requester 1) and the combinational ALU.

---
 rtl/alu_share_ctrl.sv | 110 +++++++++++
 tb/tb_alu_share_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Two-requester arbiter/sequencer around a shared combinational ALU.
// Define ALU_SHARE_RR_EN for round-robin tie-breaking; default is fixed priority.
module alu_share_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic [3:0]       resp_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic             r_id;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             w_win;
    logic             w_accept;

    always_comb begin
        w_win = ~req_valid[0];
`ifdef ALU_SHARE_RR_EN
        if (&req_valid) w_win = ~r_last;
`else
        // last grant is tracked but a tie always goes to requester 0
        if (&req_valid) w_win = 1'b0 & r_last;
`endif
    end

    assign w_accept  = reset && (r_state == IDLE) && (|req_valid);
    assign req_ready = w_accept ? {w_win, ~w_win} : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= w_win ? req_op1 : req_op0;
                r_a    <= w_win ? req_a1 : req_a0;
                r_b    <= w_win ? req_b1 : req_b0;
                r_id   <= w_win;
                r_last <= w_win;
            end
            if (r_state == EXEC) begin
                r_result <= alu_result;
                r_flags  <= {alu_negative, alu_zero,
                             alu_overflow, alu_carry_out};
            end
        end
    end

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_cntrl   = r_op;
    assign resp_valid  = (r_state == RESP);
    assign resp_id     = r_id;
    assign resp_result = r_result;
    assign resp_flags  = r_flags;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU model.
// Grant expectations follow ALU_SHARE_RR_EN when it is defined.
module tb_alu_share_ctrl;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [2:0]   req_op0, req_op1;
    logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_cntrl;
    logic         alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic         resp_valid, resp_ready, resp_id;
    logic [W-1:0] resp_result;
    logic [3:0]   resp_flags;

    int n_chk = 0;
    int n_err = 0;
    int n_id1 = 0;
    logic m_last;
    logic [W+4:0] sb[$];

    alu_share_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result),
        .resp_flags(resp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // returns {negative, zero, overflow, carry, result}
    function automatic logic [W+3:0] alu_fn(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b011: begin
                s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            default: r = a ^ b;
        endcase
        return {r[W-1], (r == '0), v, c, r};
    endfunction

    always_comb begin
        {alu_negative, alu_zero, alu_overflow, alu_carry_out, alu_result} =
            alu_fn(alu_cntrl, alu_a, alu_b);
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // Monitor: predicts each grant, pushes on accept, pops on response.
    always @(negedge clk) begin
        logic         w;
        logic [W+4:0] e;
        if (!reset) begin
            sb.delete();
            m_last = 1'b1;
        end else begin
            if (|(req_valid & req_ready)) begin
                w = ~req_valid[0];
`ifdef ALU_SHARE_RR_EN
                if (&req_valid) w = ~m_last;
`endif
                chk("grant", 128'(req_ready), 128'(w ? 2'b10 : 2'b01));
                if (w) sb.push_back({1'b1, alu_fn(req_op1, req_a1, req_b1)});
                else   sb.push_back({1'b0, alu_fn(req_op0, req_a0, req_b0)});
                m_last = w;
            end
            if (resp_valid && resp_ready) begin
                if (resp_id) n_id1++;
                chk("sb_nonempty", 128'(sb.size() > 0), 128'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("resp_id", 128'(resp_id), 128'(e[W+4]));
                    chk("resp_flags", 128'(resp_flags), 128'(e[W+3:W]));
                    chk("resp_result", 128'(resp_result), 128'(e[W-1:0]));
                end
            end
        end
    end

    task automatic issue(input logic id, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; end
        else    begin req_op0 = op; req_a0 = a; req_b0 = b; end
        req_valid[id] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            if (req_ready[id]) ok = 1'b1;
        end
        chk("accept", 128'(ok), 128'(1));
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_resp();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            if (resp_valid) ok = 1'b1;
        end
        chk("resp_seen", 128'(ok), 128'(1));
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 128'(req_ready), 128'(0));
        chk({tag, "_rvalid"}, 128'(resp_valid), 128'(0));
        chk({tag, "_rid"}, 128'(resp_id), 128'(0));
        chk({tag, "_rres"}, 128'(resp_result), 128'(0));
        chk({tag, "_rflg"}, 128'(resp_flags), 128'(0));
        chk({tag, "_alua"}, 128'(alu_a), 128'(0));
        chk({tag, "_alub"}, 128'(alu_b), 128'(0));
        chk({tag, "_aluc"}, 128'(alu_cntrl), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g[4];
        logic       g;
        logic       ok;
        int         n1;
`ifdef ALU_SHARE_RR_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset = 1'b0;
        req_valid = 2'b11;
        resp_ready = 1'b1;
        req_op0 = 3'b000; req_op1 = 3'b000;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        @(negedge clk); #1;
        chk_reset_vals("rst");
        req_valid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // single add with latency check
        issue(1'b0, 3'b010, 64'd3, 64'd4);
        chk("add_exec_novalid", 128'(resp_valid), 128'(0));
        @(posedge clk); #1;
        chk("add_valid", 128'(resp_valid), 128'(1));
        chk("add_id", 128'(resp_id), 128'(0));
        chk("add_res", 128'(resp_result), 128'(7));
        chk("add_flg", 128'(resp_flags), 128'(4'b0000));
        drain();

        // subtract 0-1 gives all ones and negative flag
        issue(1'b1, 3'b011, 64'd0, 64'd1);
        @(posedge clk); #1;
        chk("sub_id", 128'(resp_id), 128'(1));
        chk("sub_res", 128'(resp_result), 128'({W{1'b1}}));
        chk("sub_flg", 128'(resp_flags), 128'(4'b1000));
        drain();

        // contention
        req_op0 = 3'b010; req_a0 = 64'd10; req_b0 = 64'd1;
        req_op1 = 3'b001; req_a1 = 64'h30; req_b1 = 64'h0C;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            g = 1'b0;
            for (int i = 0; i < 10 && !ok; i++) begin
                @(negedge clk); #1;
                if (|req_ready) begin ok = 1'b1; g = req_ready[1]; end
            end
            chk("cont_accept", 128'(ok), 128'(1));
            chk($sformatf("cont_grant%0d", k), 128'(g), 128'(exp_g[k]));
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        drain();

        // backpressure
        resp_ready = 1'b0;
        issue(1'b0, 3'b000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        wait_resp();
        req_op1 = 3'b001; req_a1 = 64'd1; req_b1 = 64'd2;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_valid", 128'(resp_valid), 128'(1));
            chk("bp_res", 128'(resp_result), 128'(64'hF000_F000_F000_F000));
            chk("bp_ready", 128'(req_ready), 128'(0));
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_ready_resp", 128'(req_ready), 128'(0));
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("bp_next_grant", 128'(req_ready), 128'(2'b10));
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();

        // requester 1 withdraws during another operation's EXEC
        n1 = n_id1;
        issue(1'b0, 3'b001, 64'd5, 64'd8);
        req_op1 = 3'b010; req_a1 = 64'd9; req_b1 = 64'd9;
        req_valid[1] = 1'b1;
        #2;
        req_valid[1] = 1'b0;
        drain();
        drain();
        chk("withdrawn_id1", 128'(n_id1), 128'(n1));

        // async reset while holding a response
        resp_ready = 1'b0;
        issue(1'b0, 3'b010, 64'd2, 64'd3);
        wait_resp();
        chk("pre_rst_res", 128'(resp_result), 128'(5));
        @(posedge clk); #3;
        req_valid = 2'b11;
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_grant", 128'(req_ready), 128'(2'b01));
        @(posedge clk); #1;
        req_valid = 2'b00;
        resp_ready = 1'b1;
        drain();

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
